// File: rtl/swipt_pkg.sv
// Shared definitions for the harvested-power duty request path:
// controller state encoding and default sizing constants.
package swipt_pkg;

    typedef enum logic [2:0] {
        ST_ACCUM  = 3'd0,
        ST_DECIDE = 3'd1,
        ST_REQ    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_SUSP   = 3'd4
    } state_t;

    localparam int DEF_W        = 12;
    localparam int DEF_AVG_LOG2 = 3;
    localparam int DEF_HOLDOFF  = 1000;

endpackage

// File: rtl/sample_avg.sv
// Windowed sample accumulator: sums 2^AVG_LOG2 valid samples and latches
// their truncated mean on the edge that accepts the last one.
module sample_avg
    import swipt_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clear_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         done_o,
    output logic [W-1:0] avg_o
);

    logic [W+AVG_LOG2-1:0] acc_q, acc_d, sum_s;
    logic [AVG_LOG2-1:0]   cnt_q, cnt_d;
    logic [W-1:0]          avg_q, avg_d;
    logic                  done_s;

    // The accumulator is wide enough for a full window of max-scale samples.
    assign sum_s  = acc_q + {{AVG_LOG2{1'b0}}, data_i};
    assign done_s = valid_i && !clear_i && (cnt_q == {AVG_LOG2{1'b1}});
    assign done_o = done_s;
    assign avg_o  = avg_q;

    // Next-state for accumulator, sample count and latched average.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        avg_d = avg_q;
        if (clear_i) begin
            acc_d = {(W+AVG_LOG2){1'b0}};
            cnt_d = {AVG_LOG2{1'b0}};
        end else if (done_s) begin
            acc_d = {(W+AVG_LOG2){1'b0}};
            cnt_d = {AVG_LOG2{1'b0}};
            avg_d = sum_s[W+AVG_LOG2-1:AVG_LOG2];
        end else if (valid_i) begin
            acc_d = sum_s;
            cnt_d = cnt_q + AVG_LOG2'(1);
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            acc_q <= {(W+AVG_LOG2){1'b0}};
            cnt_q <= {AVG_LOG2{1'b0}};
            avg_q <= {W{1'b0}};
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
        end
    end

endmodule

// File: rtl/duty_request.sv
// Duty-adjust requester: averages harvested-power samples, compares against a
// hysteresis band around the setpoint and issues one-cycle up/down requests.
module duty_request
    import swipt_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2,
    parameter int HOLDOFF  = DEF_HOLDOFF
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         data_start,
    input  logic         data_trans,
    input  logic         data_rec,
    input  logic         adc_valid,
    input  logic [W-1:0] adc_data,
    input  logic [W-1:0] target,
    input  logic [W-1:0] hyst,
    output logic         l_rdy,
    output logic         l_up_down,
    output logic         busy
);

    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLDOFF - 1);

    state_t          state_q, state_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic            l_rdy_q, l_rdy_d;
    logic            l_up_down_q, l_up_down_d;
    logic            busy_q, busy_d;

    logic            data_any_s;
    logic            avg_clear_s, avg_valid_s, avg_done_s;
    logic [W-1:0]    avg_s;
    logic [W-1:0]    lo_s, hi_s;
    logic [W:0]      hi_wide_s;
    logic            up_s, dn_s;

    assign data_any_s = data_start || data_trans || data_rec;

    // Samples coinciding with data activity are dropped; any state other than
    // ACCUM keeps the window empty so every exit to ACCUM starts fresh.
    assign avg_valid_s = adc_valid && !data_any_s && (state_q == ST_ACCUM);
    assign avg_clear_s = data_any_s || (state_q != ST_ACCUM);

    sample_avg #(
        .W        (W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk     (clk),
        .nrst    (nrst),
        .clear_i (avg_clear_s),
        .valid_i (avg_valid_s),
        .data_i  (adc_data),
        .done_o  (avg_done_s),
        .avg_o   (avg_s)
    );

    // Dead-band limits, saturated at both ends of the unsigned range.
    assign lo_s      = (target > hyst) ? (target - hyst) : {W{1'b0}};
    assign hi_wide_s = {1'b0, target} + {1'b0, hyst};
    assign hi_s      = hi_wide_s[W] ? {W{1'b1}} : hi_wide_s[W-1:0];
    assign up_s      = (avg_s < lo_s);
    assign dn_s      = (avg_s > hi_s);

    // Next-state and registered-output logic; data activity overrides all.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        l_rdy_d     = 1'b0;
        l_up_down_d = l_up_down_q;
        if (data_any_s) begin
            state_d = ST_SUSP;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (avg_done_s) begin
                        state_d = ST_DECIDE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_DECIDE: begin
                    if (up_s || dn_s) begin
                        state_d     = ST_REQ;
                        l_rdy_d     = 1'b1;
                        l_up_down_d = up_s;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_REQ: begin
                    state_d = ST_HOLD;
                    hold_d  = {HC_W{1'b0}};
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_ACCUM;
                        hold_d  = {HC_W{1'b0}};
                    end else begin
                        hold_d = hold_q + HC_W'(1);
                    end
                end
                ST_SUSP: begin
                    state_d = ST_ACCUM;
                end
                default: begin
                    state_d = ST_ACCUM;
                    hold_d  = {HC_W{1'b0}};
                end
            endcase
        end
        busy_d = (state_d == ST_DECIDE) || (state_d == ST_REQ) || (state_d == ST_HOLD);
    end

    // State, hold counter and output registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_ACCUM;
            hold_q      <= {HC_W{1'b0}};
            l_rdy_q     <= 1'b0;
            l_up_down_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            l_rdy_q     <= l_rdy_d;
            l_up_down_q <= l_up_down_d;
            busy_q      <= busy_d;
        end
    end

    assign l_rdy     = l_rdy_q;
    assign l_up_down = l_up_down_q;
    assign busy      = busy_q;

endmodule

// File: doc/duty_request.md
DUTY_REQUEST -- requirements
Module: duty_request

Interface
REQ-001 Parameter W, default 12: width of sample, target, hysteresis and duty words.
REQ-002 Parameter AVG_LOG2, default 3: log2 of the number of samples per averaging window (window = 8).
REQ-003 Parameter HOLDOFF, default 1000: cycles to wait after each issued request before sampling resumes.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 nrst  in  1  reset; synchronous and active-low.
REQ-006 data_start  in  1  data session start flag.
REQ-007 data_trans  in  1  data transmit-in-progress flag.
REQ-008 data_rec  in  1  data receive-in-progress flag.
REQ-009 adc_valid  in  1  one-cycle strobe qualifying adc_data.
REQ-010 adc_data  in  W  measured harvested-power sample, unsigned.
REQ-011 target  in  W  power setpoint, unsigned, sampled at DECIDE.
REQ-012 hyst  in  W  dead-band half-width, unsigned, sampled at DECIDE.
REQ-013 l_rdy  out  1  one-cycle duty-adjust request strobe to the duty adjuster.
REQ-014 l_up_down  out  1  request direction: 1 = raise duty, 0 = lower duty; valid when l_rdy=1.
REQ-015 busy  out  1  high in DECIDE, REQ and HOLD.

Function
REQ-016 States SHALL be ACCUM, DECIDE, REQ, HOLD and SUSP.
REQ-017 In ACCUM, each cycle with adc_valid=1 SHALL add adc_data to an accumulator of width W+AVG_LOG2 and increment the sample count.
REQ-018 On the edge that accepts sample 2^AVG_LOG2, the block SHALL enter DECIDE with avg = accumulator >> AVG_LOG2 (truncating); the accumulator SHALL NOT overflow.
REQ-019 In DECIDE, lo = target - hyst saturated at 0 and hi = target + hyst saturated at 2^W-1, both computed without wrap.
REQ-020 avg < lo SHALL select an up request; avg > hi a down request; lo <= avg <= hi no request.
REQ-021 DECIDE with a request -> REQ; DECIDE with no request -> ACCUM with accumulator and count cleared.
REQ-022 In REQ, l_rdy SHALL be 1 for exactly one cycle; l_rdy is therefore high in the second cycle after the last-sample cycle.
REQ-023 l_up_down SHALL update only on entry to REQ and hold its value otherwise.
REQ-024 REQ -> HOLD; HOLD SHALL last exactly HOLDOFF cycles, ignore adc_valid, then enter ACCUM with accumulator and count cleared.
REQ-025 When any of data_start, data_trans or data_rec is 1, the block SHALL enter SUSP from any state on the next edge; this takes priority over all other transitions.
REQ-026 Data activity during DECIDE SHALL suppress the pending request, so l_rdy never rises.
REQ-027 In SUSP, l_rdy=0 and the accumulator and count SHALL be cleared. SUSP -> ACCUM on the first cycle in which all three data flags are 0.
REQ-028 An adc_valid arriving in the same cycle as a data flag SHALL be discarded.

Reset
REQ-029 When nrst=0 at a rising edge, the block SHALL enter state ACCUM with accumulator=0, count=0, hold counter=0, l_rdy=0, l_up_down=0 and busy=0.
REQ-030 Reset SHALL abort any state, including REQ and HOLD, with no further l_rdy pulse.

Structure
REQ-031 Shared package swipt_pkg SHALL hold the state enumeration and the default W, AVG_LOG2 and HOLDOFF constants.
REQ-032 The accumulate/count/average datapath SHALL be the sub-module sample_avg, with clear, valid, data and done/avg ports.

Verification (W=12, AVG_LOG2=3, HOLDOFF=10, target=400, hyst=20)
REQ-033 Up request: 8 samples of 300 -> single l_rdy pulse with l_up_down=1 two cycles after the 8th sample; busy high for 12 cycles; samples during HOLD ignored.
REQ-034 Down request and dead band: 8 samples of 500 -> one pulse with l_up_down=0; then 8 samples of 410 -> no pulse, l_up_down stays 0, and the next window starts immediately.
REQ-035 Suspend: data_trans=1 after 5 samples of 300 -> no pulse; after release, 3 more samples -> no pulse; 8 fresh samples required for a pulse.
REQ-036 DECIDE collision: data_start=1 in the DECIDE cycle -> no l_rdy, state SUSP.
REQ-037 Saturation: target=10, hyst=20, 8 samples of 0 -> no pulse (lo=0). target=4090, hyst=20, 8 samples of 4095 -> avg=4095 and no pulse (hi=4095).
REQ-038 Reset: nrst=0 for one cycle mid-HOLD -> outputs 0 and state ACCUM; 8 samples of 300 -> normal up pulse.
